// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;
  localparam int REG_ZERO  = 0;
  localparam int WP_ALU    = 0;  // write port 0: ALU writeback
  localparam int WP_LOAD   = 1;  // write port 1: load writeback
  localparam int NUM_WP    = 2;

  // Ceiling log2 for tools without $clog2.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: picks an in-flight write (port 0 first) or the stored word.
module regfile_bypass_mux import regfile_pkg::*; #(
  parameter int DW     = DW_DEF,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [AW-1:0]     rd_addr_i,
  input  logic [DW-1:0]     stored_i,
  input  logic [1:0]        wt_en_i,
  input  logic [2*AW-1:0]   wt_addr_i,
  input  logic [2*DW-1:0]   wt_data_i,
  output logic [DW-1:0]     rd_data_o,
  output logic              hit_o
);
  logic hit_alu, hit_load;

  // Address match per write port; r0 never forwards.
  always_comb begin
    hit_alu  = wt_en_i[WP_ALU] && (wt_addr_i[WP_ALU*AW +: AW] == rd_addr_i) &&
               (rd_addr_i != AW'(REG_ZERO));
    hit_load = wt_en_i[WP_LOAD] && (wt_addr_i[WP_LOAD*AW +: AW] == rd_addr_i) &&
               (rd_addr_i != AW'(REG_ZERO));
    hit_o     = BYPASS && (hit_alu || hit_load);
    rd_data_o = stored_i;
    if (BYPASS && hit_alu)       rd_data_o = wt_data_i[WP_ALU*DW +: DW];
    else if (BYPASS && hit_load) rd_data_o = wt_data_i[WP_LOAD*DW +: DW];
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two writes,
// optional write-through bypass and a pending-load busy scoreboard.
module regfile_mp import regfile_pkg::*; #(
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*clog2(DEPTH)-1:0]  rd_addr,
  output logic [NUM_RD*DW-1:0]            rd_data,
  output logic [NUM_RD-1:0]               rd_busy,
  input  logic [1:0]                      wt_en,
  input  logic [2*clog2(DEPTH)-1:0]       wt_addr,
  input  logic [2*DW-1:0]                 wt_data,
  input  logic                            busy_set_en,
  input  logic [clog2(DEPTH)-1:0]         busy_set_addr,
  output logic                            wt_conflict
);
  localparam int AW = clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] regs_q;
  logic [DEPTH-1:0]         busy_q;
  logic                     conflict_q, conflict_d;

  // Both ports hitting the same real register this cycle.
  always_comb begin
    conflict_d = wt_en[WP_ALU] && wt_en[WP_LOAD] &&
                 (wt_addr[WP_ALU*AW +: AW] == wt_addr[WP_LOAD*AW +: AW]) &&
                 (wt_addr[WP_ALU*AW +: AW] != AW'(REG_ZERO));
  end

  // Storage, scoreboard and conflict flag. Port 1 is applied first so port 0
  // overrides on a shared address; busy set comes last so a new load wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int k = NUM_WP - 1; k >= 0; k--) begin
        if (wt_en[k] && (wt_addr[k*AW +: AW] != AW'(REG_ZERO))) begin
          regs_q[wt_addr[k*AW +: AW]] <= wt_data[k*DW +: DW];
          busy_q[wt_addr[k*AW +: AW]] <= 1'b0;
        end
      end
      if (busy_set_en && (busy_set_addr != AW'(REG_ZERO)))
        busy_q[busy_set_addr] <= 1'b1;
      conflict_q <= conflict_d;
    end
  end

  assign wt_conflict = conflict_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] mux_data;
    logic          hit;

    assign ra = rd_addr[i*AW +: AW];

    regfile_bypass_mux #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_mux (
      .rd_addr_i (ra),
      .stored_i  (regs_q[ra]),
      .wt_en_i   (wt_en),
      .wt_addr_i (wt_addr),
      .wt_data_i (wt_data),
      .rd_data_o (mux_data),
      .hit_o     (hit)
    );

    // Outputs are forced quiet while reset is held.
    assign rd_data[i*DW +: DW] = rst ? '0 : mux_data;
    assign rd_busy[i]          = !rst && busy_q[ra] && !hit;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: stimulus pushes expectations, a negedge monitor checks them.
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the BYPASS=1 (a) and BYPASS=0 (b) 32x32 instances.
  logic        rst;
  logic [9:0]  rd_addr;
  logic [1:0]  wt_en;
  logic [9:0]  wt_addr;
  logic [63:0] wt_data;
  logic        bse;
  logic [4:0]  bsa;
  logic [63:0] a_data, b_data;
  logic [1:0]  a_busy, b_busy;
  logic        a_conf, b_conf;

  // Four-port 16x16 instance (c).
  logic [15:0] c_rd_addr;
  logic [1:0]  c_wt_en;
  logic [7:0]  c_wt_addr;
  logic [31:0] c_wt_data;
  logic        c_bse;
  logic [3:0]  c_bsa;
  logic [63:0] c_data;
  logic [3:0]  c_busy;
  logic        c_conf;

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(a_data), .rd_busy(a_busy),
    .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data), .busy_set_en(bse),
    .busy_set_addr(bsa), .wt_conflict(a_conf));

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_data), .rd_busy(b_busy),
    .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data), .busy_set_en(bse),
    .busy_set_addr(bsa), .wt_conflict(b_conf));

  regfile_mp #(.DW(16), .DEPTH(16), .NUM_RD(4), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .rd_addr(c_rd_addr), .rd_data(c_data), .rd_busy(c_busy),
    .wt_en(c_wt_en), .wt_addr(c_wt_addr), .wt_data(c_wt_data), .busy_set_en(c_bse),
    .busy_set_addr(c_bsa), .wt_conflict(c_conf));

  typedef struct {
    bit          is_c;
    logic [63:0] ad;
    logic [3:0]  ab;
    logic [63:0] bd;
    logic [1:0]  bb;
    logic        cf;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: drains every expectation queued since the last negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t  e;
      string n;
      e = q.pop_front();
      n = qn.pop_front();
      if (e.is_c) begin
        chk({n, " c_data"}, c_data, e.ad);
        chk({n, " c_busy"}, 64'(c_busy), 64'(e.ab));
        chk({n, " c_conf"}, 64'(c_conf), 64'(e.cf));
      end else begin
        chk({n, " a_data"}, a_data, e.ad);
        chk({n, " a_busy"}, 64'(a_busy), 64'(e.ab[1:0]));
        chk({n, " a_conf"}, 64'(a_conf), 64'(e.cf));
        chk({n, " b_data"}, b_data, e.bd);
        chk({n, " b_busy"}, 64'(b_busy), 64'(e.bb));
        chk({n, " b_conf"}, 64'(b_conf), 64'(e.cf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                     logic [4:0] wa1, logic [31:0] wd1, logic bs, logic [4:0] ba,
                     logic [4:0] r0, logic [4:0] r1);
    wt_en   = we;
    wt_addr = {wa1, wa0};
    wt_data = {wd1, wd0};
    bse     = bs;
    bsa     = ba;
    rd_addr = {r1, r0};
  endtask

  task automatic exp_ab(string n, logic [31:0] a0, logic [31:0] a1, logic [1:0] ab,
                        logic [31:0] b0, logic [31:0] b1, logic [1:0] bb, logic cf);
    exp_t e;
    e.is_c = 1'b0;
    e.ad = {a1, a0};
    e.ab = {2'b00, ab};
    e.bd = {b1, b0};
    e.bb = bb;
    e.cf = cf;
    q.push_back(e);
    qn.push_back(n);
  endtask

  task automatic exp_c(string n, logic [63:0] d);
    exp_t e;
    e.is_c = 1'b1;
    e.ad = d;
    e.ab = 4'b0000;
    e.bd = '0;
    e.bb = 2'b00;
    e.cf = 1'b0;
    q.push_back(e);
    qn.push_back(n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    c_rd_addr = '0; c_wt_en = '0; c_wt_addr = '0; c_wt_data = '0;
    c_bse = 1'b0; c_bsa = '0;

    // Reset state
    step();
    exp_ab("reset", 0, 0, 2'b00, 0, 0, 2'b00, 1'b0);

    // 1: reset sweep
    step(); rst = 1'b0;
    drv(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    exp_ab("wr_r5", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 0, 2'b00, 1'b0);
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    exp_ab("rd_r5", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0);
    step(); rst = 1'b1;
    drv(2'b01, 5'd5, 32'd1, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd5);
    exp_ab("in_rst", 0, 0, 2'b00, 0, 0, 2'b00, 1'b0);
    step(); rst = 1'b0;
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    exp_ab("post_rst", 0, 0, 2'b00, 0, 0, 2'b00, 1'b0);

    // 2: dual write plus read-after-write
    step();
    drv(2'b11, 5'd15, 32'd1234, 5'd7, 32'd5678, 1'b0, 5'd0, 5'd15, 5'd7);
    exp_ab("dual_wr", 32'd1234, 32'd5678, 2'b00, 0, 0, 2'b00, 1'b0);
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd15, 5'd7);
    exp_ab("dual_rd", 32'd1234, 32'd5678, 2'b00, 32'd1234, 32'd5678, 2'b00, 1'b0);

    // 3: r0 protection
    step();
    drv(2'b11, 5'd0, 32'd5, 5'd0, 32'd5, 1'b1, 5'd0, 5'd0, 5'd0);
    exp_ab("r0_wr", 0, 0, 2'b00, 0, 0, 2'b00, 1'b0);
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    exp_ab("r0_rd", 0, 0, 2'b00, 0, 0, 2'b00, 1'b0);

    // 4: write conflict, port 0 wins, flag lasts one cycle
    step();
    drv(2'b11, 5'd9, 32'hAAAA, 5'd9, 32'h5555, 1'b0, 5'd0, 5'd9, 5'd15);
    exp_ab("conf_wr", 32'hAAAA, 32'd1234, 2'b00, 0, 32'd1234, 2'b00, 1'b0);
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
    exp_ab("conf_flag", 32'hAAAA, 32'hAAAA, 2'b00, 32'hAAAA, 32'hAAAA, 2'b00, 1'b1);
    step();
    exp_ab("conf_drop", 32'hAAAA, 32'hAAAA, 2'b00, 32'hAAAA, 32'hAAAA, 2'b00, 1'b0);

    // 5: scoreboard
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd7);
    exp_ab("bset", 0, 32'd5678, 2'b00, 0, 32'd5678, 2'b00, 1'b0);
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd7);
    exp_ab("busy", 0, 32'd5678, 2'b01, 0, 32'd5678, 2'b01, 1'b0);
    step();
    drv(2'b10, 5'd0, 32'd0, 5'd12, 32'd77, 1'b0, 5'd0, 5'd12, 5'd12);
    exp_ab("ld_wb", 32'd77, 32'd77, 2'b00, 0, 0, 2'b11, 1'b0);
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd12);
    exp_ab("busy_clr", 32'd77, 32'd77, 2'b00, 32'd77, 32'd77, 2'b00, 1'b0);
    step();
    drv(2'b01, 5'd12, 32'd88, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd3);
    exp_ab("set_wr", 32'd88, 0, 2'b00, 32'd77, 0, 2'b00, 1'b0);
    step();
    drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd3);
    exp_ab("set_wins", 32'd88, 0, 2'b01, 32'd88, 0, 2'b01, 1'b0);

    // 6: four read ports, 16-bit words
    step();
    c_wt_en = 2'b11; c_wt_addr = {4'd2, 4'd1}; c_wt_data = {16'd2, 16'd1};
    c_rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    exp_c("c_wr12", {16'd0, 16'd0, 16'd2, 16'd1});
    step();
    c_wt_addr = {4'd4, 4'd3}; c_wt_data = {16'd4, 16'd3};
    exp_c("c_wr34", {16'd4, 16'd3, 16'd2, 16'd1});
    step();
    c_wt_en = 2'b00;
    exp_c("c_rd", {16'd4, 16'd3, 16'd2, 16'd1});
    step();
    c_rd_addr = {4'd2, 4'd4, 4'd1, 4'd3};
    exp_c("c_perm", {16'd2, 16'd4, 16'd1, 16'd3});
    step();
    c_rd_addr = {4'd3, 4'd3, 4'd3, 4'd3};
    exp_c("c_same", {16'd3, 16'd3, 16'd3, 16'd3});

    step();
    step();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file. Successor to the 32x32 two-read/one-write MIPS register file.
- Generalises data width, depth and read-port count.
- Adds a second write port (port 0 = ALU writeback, port 1 = load writeback), same-cycle write-through bypass, and a per-register pending-load scoreboard.
- Sits between decode (reads, busy checks) and writeback (writes) in the MIPS32i pipeline.

Parameters:
DW, 32, data width in bits
DEPTH, 32, number of registers; power of two, at least 2
AW, $clog2(DEPTH), address width; localparam, not overridable
NUM_RD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = same-cycle write-through forwarding to read ports; 0 = reads return stored value only

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
rd_addr  in  NUM_RD*AW  read addresses; port i occupies [i*AW +: AW]
rd_data  out  NUM_RD*DW  read data; port i occupies [i*DW +: DW]
rd_busy  out  NUM_RD  port i reads a register with a load pending and no bypass hit
wt_en  in  2  write enables, one per write port
wt_addr  in  2*AW  write addresses; port k occupies [k*AW +: AW]
wt_data  in  2*DW  write data; port k occupies [k*DW +: DW]
busy_set_en  in  1  mark busy_set_addr as pending (load issued)
busy_set_addr  in  AW  register to mark pending
wt_conflict  out  1  registered flag: previous cycle had both write ports enabled to the same nonzero address

Behaviour:
- Reset (synchronous, active-high):
  - At the rising edge with rst=1, all registers clear to 0, all busy bits clear to 0, and wt_conflict clears to 0.
  - While rst=1, rd_data reads 0 on all ports and rd_busy reads 0, combinationally.
  - Writes and busy_set_en are ignored in any cycle with rst=1, including reset asserted mid-sequence.
- Register 0:
  - Always reads 0.
  - Writes to it are discarded.
  - busy_set_en to it is discarded; it is never busy.
  - It never generates a bypass hit or a conflict.
- Writes:
  - On the rising edge, reg[wt_addr[k]] <= wt_data[k] for each k with wt_en[k]=1 and nonzero address.
  - Both ports to different addresses: both writes land.
  - Both ports to the same nonzero address: port 0 wins, and wt_conflict=1 in the following cycle only.
- Reads (zero-cycle latency, combinational):
  - BYPASS=1: if any enabled write port targets rd_addr[i] (nonzero), rd_data[i] takes that port's wt_data, with port 0 priority. Otherwise it takes the stored value.
  - BYPASS=0: rd_data[i] = stored value; a write becomes visible the cycle after its edge.
  - Any read port may read any address, including the same address as another port.
- Scoreboard:
  - busy[a] is set at the edge when busy_set_en=1 and busy_set_addr=a (nonzero).
  - busy[a] is cleared at the edge when any enabled write targets a.
  - Set and clear on the same address in the same cycle: set wins (new load issued).
  - rd_busy[i] = busy[rd_addr[i]], masked to 0 when BYPASS=1 and a write to rd_addr[i] is present in the current cycle.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - default DW/DEPTH
  - REG_ZERO constant (address 0)
  - function clog2 for tools lacking $clog2
  - write-port index constants WP_ALU=0 and WP_LOAD=1
- One sub-module, regfile_bypass_mux. It takes one read address, the stored word, both write ports and BYPASS. It returns the selected data and the bypass-hit flag. It is instantiated NUM_RD times in a generate loop.
- Storage array, busy vector and wt_conflict register stay in regfile_mp.

Test Plan:
1. Reset sweep: write 0xDEADBEEF to r5, then assert rst one cycle → r5 reads 0 on every port, rd_busy=0, wt_conflict=0.
2. Dual write plus read-after-write: port0 r15=1234 and port1 r7=5678 in one cycle, reading r15/r7 on ports 0/1 the same cycle → BYPASS=1: 1234/5678 that cycle. BYPASS=0: old values that cycle, then 1234/5678 next cycle.
3. r0 protection: write 5 to r0 on both ports and busy_set r0 → r0 reads 0, rd_busy 0, wt_conflict stays 0.
4. Write conflict: port0 r9=0xAAAA and port1 r9=0x5555 in the same cycle → r9=0xAAAA afterwards, and wt_conflict=1 for exactly one cycle.
5. Scoreboard:
   - busy_set r12 → next cycle rd_busy=1 for a port reading r12.
   - Port1 write r12=77 in a later cycle → that cycle rd_busy=0 and rd_data=77 (BYPASS=1). Busy stays clear afterwards.
   - Simultaneous busy_set r12 and write r12 → r12 remains busy.
6. NUM_RD=4, DW=16, DEPTH=16: all four ports read distinct registers holding 1,2,3,4 → correct 16-bit values on each slice, with no cross-port aliasing.
